bus_if: RTL and testbench

- Per-stage memory access unit between a pipeline stage (IF or MEM) and its storage targets.
- Decodes each access: the SPM region goes straight to one port of the dual-port scratchpad; every other address goes to the shared system bus through a request/grant/ready FSM.
- Drives `busy` back to the stage so the pipeline stalls while a bus access is outstanding.
- One instance per stage; the IF instance feeds SPM port A and the MEM instance feeds SPM port B.

---
 rtl/bus_if_pkg.sv | 40 ++++
 rtl/bus_if.sv | 143 ++++++++++++++
 tb/tb_bus_if.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_if_pkg.sv
// Shared constants and types for the per-stage memory access unit.
package bus_if_pkg;

  // Address / data geometry
  localparam int unsigned ADDR_W     = 30;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REGION_MSB = 29;
  localparam int unsigned REGION_LSB = 27;
  localparam int unsigned REGION_W   = REGION_MSB - REGION_LSB + 1;

  // Scratchpad region select and scratchpad word-address width
  localparam logic [REGION_W-1:0] BUS_IF_SPM_REGION = 3'b011;
  localparam int unsigned         BUS_IF_SPM_ADDR_W = 12;

  // Direction and strobe polarities
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // FSM encodings
  localparam logic [1:0] BUS_IF_STATE_IDLE   = 2'd0;
  localparam logic [1:0] BUS_IF_STATE_REQ    = 2'd1;
  localparam logic [1:0] BUS_IF_STATE_ACCESS = 2'd2;
  localparam logic [1:0] BUS_IF_STATE_STALL  = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = BUS_IF_STATE_IDLE,
    StReq    = BUS_IF_STATE_REQ,
    StAccess = BUS_IF_STATE_ACCESS,
    StStall  = BUS_IF_STATE_STALL
  } bus_if_state_e;

  // True when the word address falls in the scratchpad region
  function automatic logic is_spm_addr(input logic [ADDR_W-1:0]   addr,
                                       input logic [REGION_W-1:0] region);
    return addr[REGION_MSB:REGION_LSB] == region;
  endfunction

endpackage

// File: rtl/bus_if.sv
// Per-stage memory access unit: scratchpad accesses are passed straight through,
// everything else goes to the shared bus via a request/grant/ready handshake.
module bus_if
  import bus_if_pkg::*;
#(
  parameter logic [REGION_W-1:0] SPM_REGION = BUS_IF_SPM_REGION,
  parameter int unsigned         SPM_ADDR_W = BUS_IF_SPM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_,
  // pipeline control
  input  logic                  stall,
  input  logic                  flush,
  output logic                  busy,
  // stage side
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  as_,
  input  logic                  rw,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  // scratchpad port
  input  logic [DATA_W-1:0]     spm_rd_data,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [DATA_W-1:0]     spm_wr_data,
  // shared bus
  input  logic [DATA_W-1:0]     bus_rd_data,
  input  logic                  bus_rdy_,
  input  logic                  bus_grnt_,
  output logic                  bus_req_,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic                  bus_as_,
  output logic                  bus_rw,
  output logic [DATA_W-1:0]     bus_wr_data
);

  bus_if_state_e     r_state;
  logic              r_bus_req_;
  logic              r_bus_as_;
  logic              r_bus_rw;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wr_data;
  logic [DATA_W-1:0] r_rd_buf;

  logic w_is_spm;
  logic w_strobe;
  logic w_accept;

  assign w_is_spm = is_spm_addr(addr, SPM_REGION);
  // flush only blocks new accesses; it never touches one already on the bus
  assign w_strobe = (r_state == StIdle) && (as_ == ENABLE_) && !flush;
  assign w_accept = w_strobe && !w_is_spm;

  // Scratchpad path: address, direction and data follow the stage directly
  assign spm_addr    = addr[SPM_ADDR_W-1:0];
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;
  assign spm_as_     = (w_strobe && w_is_spm) ? ENABLE_ : DISABLE_;

  assign bus_req_    = r_bus_req_;
  assign bus_as_     = r_bus_as_;
  assign bus_rw      = r_bus_rw;
  assign bus_addr    = r_bus_addr;
  assign bus_wr_data = r_bus_wr_data;

  // Bus handshake FSM with registered bus-side outputs
  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_state       <= StIdle;
      r_bus_req_    <= DISABLE_;
      r_bus_as_     <= DISABLE_;
      r_bus_rw      <= READ;
      r_bus_addr    <= '0;
      r_bus_wr_data <= '0;
      r_rd_buf      <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_bus_addr    <= addr;
            r_bus_rw      <= rw;
            r_bus_wr_data <= wr_data;
            r_bus_req_    <= ENABLE_;
            r_state       <= StReq;
          end
        end
        StReq: begin
          // ready is deliberately ignored here; it only counts once the strobe has gone out
          if (bus_grnt_ == ENABLE_) begin
            r_bus_as_ <= ENABLE_;
            r_state   <= StAccess;
          end
        end
        StAccess: begin
          r_bus_as_ <= DISABLE_;
          if (bus_rdy_ == ENABLE_) begin
            // writes leave zero behind so a stalled write reports rd_data=0
            r_rd_buf   <= (r_bus_rw == READ) ? bus_rd_data : '0;
            r_bus_req_ <= DISABLE_;
            r_state    <= stall ? StStall : StIdle;
          end
        end
        StStall: begin
          if (!stall) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Stage-facing busy and read-data mux
  always_comb begin
    busy    = 1'b0;
    rd_data = '0;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          busy = 1'b1;
        end else if (w_is_spm) begin
          rd_data = spm_rd_data;
        end
      end
      StReq: begin
        busy = 1'b1;
      end
      StAccess: begin
        if (bus_rdy_ == ENABLE_) begin
          rd_data = (r_bus_rw == READ) ? bus_rd_data : '0;
        end else begin
          busy = 1'b1;
        end
      end
      StStall: begin
        rd_data = r_rd_buf;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_if.sv
// Self-checking bench for bus_if: directed scenarios plus randomised bus
// transactions whose expected cycle-by-cycle behaviour is derived from the
// transaction parameters (grant wait, ready wait, stall length).
module tb_bus_if;

  logic        clk = 1'b0;
  logic        reset_;
  logic        stall, flush;
  logic        busy;
  logic [29:0] addr;
  logic        as_, rw;
  logic [31:0] wr_data, rd_data;
  logic [31:0] spm_rd_data;
  logic [11:0] spm_addr;
  logic        spm_as_, spm_rw;
  logic [31:0] spm_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_, bus_grnt_;
  logic        bus_req_;
  logic [29:0] bus_addr;
  logic        bus_as_, bus_rw;
  logic [31:0] bus_wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  bus_if dut (
    .clk         (clk),
    .reset_      (reset_),
    .stall       (stall),
    .flush       (flush),
    .busy        (busy),
    .addr        (addr),
    .as_         (as_),
    .rw          (rw),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .spm_rd_data (spm_rd_data),
    .spm_addr    (spm_addr),
    .spm_as_     (spm_as_),
    .spm_rw      (spm_rw),
    .spm_wr_data (spm_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_rdy_    (bus_rdy_),
    .bus_grnt_   (bus_grnt_),
    .bus_req_    (bus_req_),
    .bus_addr    (bus_addr),
    .bus_as_     (bus_as_),
    .bus_rw      (bus_rw),
    .bus_wr_data (bus_wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // inputs change just after the rising edge, outputs are sampled at the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [29:0] non_spm_addr();
    logic [29:0] a;
    a = 30'($urandom);
    if (a[29:27] == 3'b011) a[29] = 1'b1;
    return a;
  endfunction

  // One complete bus transfer: accept, gw extra grant-wait cycles, grant,
  // rw_ extra ready-wait cycles, ready, then ns stall cycles.
  task automatic run_bus(input string tag, input logic [29:0] a, input logic dir,
                         input logic [31:0] wd, input logic [31:0] rdat,
                         input int gw, input int rw_, input int ns);
    logic [31:0] exp_rd;
    exp_rd = dir ? rdat : 32'h0;
    // accept cycle in IDLE
    addr = a; as_ = 1'b0; rw = dir; wr_data = wd; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    mid();
    chk({tag, " accept busy"}, busy, 1);
    chk({tag, " accept req_"}, bus_req_, 1);
    tick();
    // waiting for grant; a stray ready here must not matter
    for (int g = 0; g < gw; g++) begin
      bus_rdy_ = 1'($urandom_range(0, 1));
      mid();
      chk({tag, " req busy"}, busy, 1);
      chk({tag, " req req_"}, bus_req_, 0);
      chk({tag, " req as_"}, bus_as_, 1);
      tick();
    end
    bus_grnt_ = 1'b0;
    bus_rdy_  = 1'($urandom_range(0, 1));
    mid();
    chk({tag, " grant busy"}, busy, 1);
    chk({tag, " grant addr"}, {2'b0, bus_addr}, {2'b0, a});
    chk({tag, " grant rw"}, bus_rw, dir);
    chk({tag, " grant wdata"}, bus_wr_data, wd);
    tick();
    bus_grnt_ = 1'b1;
    for (int r = 0; r < rw_; r++) begin
      bus_rdy_ = 1'b1;
      mid();
      chk({tag, " wait busy"}, busy, 1);
      chk({tag, " wait req_"}, bus_req_, 0);
      chk({tag, " wait as_"}, bus_as_, (r == 0) ? 1'b0 : 1'b1);
      tick();
    end
    // ready cycle
    bus_rdy_ = 1'b0; bus_rd_data = rdat; stall = (ns > 0); as_ = 1'b1;
    mid();
    chk({tag, " rdy busy"}, busy, 0);
    chk({tag, " rdy rd_data"}, rd_data, exp_rd);
    chk({tag, " rdy as_"}, bus_as_, (rw_ == 0) ? 1'b0 : 1'b1);
    chk({tag, " rdy req_"}, bus_req_, 0);
    tick();
    bus_rdy_ = 1'b1; bus_rd_data = $urandom;
    // stall: a fresh non-SPM request is offered but must not be taken
    for (int s = 0; s < ns; s++) begin
      stall = (s < ns - 1);
      as_   = (s < ns - 1) ? 1'b0 : 1'b1;
      addr  = non_spm_addr();
      mid();
      chk({tag, " stall busy"}, busy, 0);
      chk({tag, " stall rd_data"}, rd_data, exp_rd);
      chk({tag, " stall req_"}, bus_req_, 1);
      tick();
    end
    stall = 1'b0; as_ = 1'b1;
    mid();
    chk({tag, " done busy"}, busy, 0);
    chk({tag, " done req_"}, bus_req_, 1);
    chk({tag, " done as_"}, bus_as_, 1);
    tick();
  endtask

  initial begin
    logic [29:0] a;
    logic        f, s;
    reset_ = 1'b0; stall = 1'b0; flush = 1'b0; addr = '0; as_ = 1'b1; rw = 1'b1;
    wr_data = '0; spm_rd_data = 32'h1111_2222; bus_rd_data = '0;
    bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
    tick(); tick();
    mid();
    chk("reset req_", bus_req_, 1);
    chk("reset as_", bus_as_, 1);
    chk("reset rw", bus_rw, 1);
    chk("reset addr", {2'b0, bus_addr}, 0);
    chk("reset wdata", bus_wr_data, 0);
    chk("reset busy", busy, 0);
    reset_ = 1'b1;
    tick();

    // SPM read
    addr = 30'h1800_0010; as_ = 1'b0; rw = 1'b1; spm_rd_data = 32'hDEAD_BEEF;
    mid();
    chk("spm as_", spm_as_, 0);
    chk("spm addr", {20'b0, spm_addr}, 32'h010);
    chk("spm busy", busy, 0);
    chk("spm rd_data", rd_data, 32'hDEAD_BEEF);
    chk("spm rw", spm_rw, 1);
    tick();
    as_ = 1'b1;
    mid();
    chk("spm no req_", bus_req_, 1);
    tick();

    run_bus("rd0", 30'h0000_0040, 1'b1, 32'h0, 32'h1234_5678, 0, 0, 0);
    run_bus("wrstall", 30'h0000_0080, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_0000, 0, 0, 2);
    run_bus("rdstall", 30'h0000_00C0, 1'b1, 32'h0, 32'hCAFE_F00D, 1, 1, 6);

    // flush with non-SPM and SPM addresses
    addr = 30'h0000_0100; as_ = 1'b0; flush = 1'b1;
    mid();
    chk("flush bus busy", busy, 0);
    tick();
    mid();
    chk("flush bus req_", bus_req_, 1);
    addr = 30'h1800_0020;
    mid();
    chk("flush spm as_", spm_as_, 1);
    chk("flush spm busy", busy, 0);
    tick();
    flush = 1'b0; as_ = 1'b1;

    // reset while in ACCESS, then a late ready
    addr = 30'h0000_0200; as_ = 1'b0; rw = 1'b1;
    tick();
    as_ = 1'b1; bus_grnt_ = 1'b0;
    tick();
    bus_grnt_ = 1'b1; reset_ = 1'b0;
    tick();
    reset_ = 1'b1;
    mid();
    chk("rstmid req_", bus_req_, 1);
    chk("rstmid as_", bus_as_, 1);
    chk("rstmid busy", busy, 0);
    chk("rstmid addr", {2'b0, bus_addr}, 0);
    bus_rdy_ = 1'b0; bus_rd_data = 32'hBAD0_BAD0;
    tick();
    mid();
    chk("late rdy busy", busy, 0);
    chk("late rdy rd_data", rd_data, 0);
    chk("late rdy req_", bus_req_, 1);
    tick();
    bus_rdy_ = 1'b1;

    // randomised traffic
    for (int i = 0; i < 25; i++) begin
      run_bus("rand", non_spm_addr(), 1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      // an idle-cycle probe: SPM access, or a non-SPM address that must not start
      f = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      spm_rd_data = $urandom;
      if (s) begin
        a = 30'($urandom);
        a[29:27] = 3'b011;
        as_ = 1'b0;
      end else begin
        a = non_spm_addr();
        as_ = f ? 1'b0 : 1'b1;
      end
      addr = a; flush = f;
      mid();
      chk("rand idle busy", busy, 0);
      chk("rand idle spm_as_", spm_as_, (s && !f) ? 1'b0 : 1'b1);
      chk("rand idle rd_data", rd_data, s ? spm_rd_data : 32'h0);
      chk("rand idle spm_addr", {20'b0, spm_addr}, {20'b0, a[11:0]});
      tick();
      flush = 1'b0; as_ = 1'b1;
      mid();
      chk("rand idle req_", bus_req_, 1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
